// File: rtl/count_monitor.sv
// count_monitor: checks that a sampled up-counter advances by exactly one per
// valid sample (modulo 2^WIDTH). It locks onto the sequence, flags wraps and
// sequence errors as one-cycle pulses, and keeps saturating wrap/error tallies.
//
// Handshake: count_in is qualified by valid alone. There is no backpressure.
// An edge with valid=1 is a sample. An edge with valid=0 leaves prev, the FSM
// and the tallies unchanged and drives both pulses low.
module count_monitor #(
  parameter int WIDTH       = 4,
  parameter int WRAP_W      = 8,
  parameter int ERR_W       = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              valid,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              error_pulse,
  output logic [ERR_W-1:0]  error_count,
  output logic              sticky_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Lock target as a 4-bit value. LOCK_CYCLES is limited to 1..15.
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CYCLES);

  // state is the FSM register. Checkers can probe it hierarchically.
  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_val;
  logic [3:0]       match_cnt;
  logic [3:0]       match_inc;
  logic [3:0]       match_next;
  logic             wrap_event;
  logic             err_event;

  assign exp_val   = prev + WIDTH'(1);
  assign match_inc = match_cnt + 4'd1;

  // Next-state logic: sequence comparison, lock acquisition and event detection.
  always_comb begin
    state_next = state;
    match_next = match_cnt;
    wrap_event = 1'b0;
    err_event  = 1'b0;
    if (valid) begin
      case (state)
        IDLE: begin
          state_next = ACQUIRE;
          match_next = 4'd0;
        end
        ACQUIRE: begin
          if (count_in == exp_val) begin
            match_next = match_inc;
            if (match_inc == LOCK_TARGET) begin
              state_next = LOCKED;
            end
          end else begin
            // A mismatch while acquiring only restarts the lock count.
            match_next = 4'd0;
          end
        end
        LOCKED: begin
          if (count_in == exp_val) begin
            // An all-ones prev followed by the expected value means a wrap to 0.
            if (prev == '1) begin
              wrap_event = 1'b1;
            end
          end else begin
            err_event  = 1'b1;
            match_next = 4'd0;
            state_next = ACQUIRE;
          end
        end
        default: begin
          state_next = IDLE;
          match_next = 4'd0;
        end
      endcase
    end
  end

  // FSM state, last sampled value and lock counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      match_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
      if (valid) begin
        prev <= count_in;
      end
    end
  end

  // Registered lock flag and event pulses. Clear does not affect these.
  always_ff @(posedge clock) begin
    if (reset) begin
      locked      <= 1'b0;
      wrap_pulse  <= 1'b0;
      error_pulse <= 1'b0;
    end else begin
      locked      <= (state_next == LOCKED);
      wrap_pulse  <= wrap_event;
      error_pulse <= err_event;
    end
  end

  // Saturating tallies and sticky error. Clear wins over a same-edge event.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrap_count   <= '0;
      error_count  <= '0;
      sticky_error <= 1'b0;
    end else if (clear) begin
      wrap_count   <= '0;
      error_count  <= '0;
      sticky_error <= 1'b0;
    end else begin
      if (wrap_event && (wrap_count != '1)) begin
        wrap_count <= wrap_count + WRAP_W'(1);
      end
      if (err_event) begin
        sticky_error <= 1'b1;
        if (error_count != '1) begin
          error_count <= error_count + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// Directed testbench for count_monitor. The main instance uses the default
// parameters. A second instance with 2-bit tallies receives the same inputs
// so that saturation can be checked.
module tb_count_monitor;

  logic       clock;
  logic       reset;
  logic [3:0] count_in;
  logic       valid;
  logic       clear;

  logic       locked;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       error_pulse;
  logic [7:0] error_count;
  logic       sticky_error;

  logic       locked2;
  logic       wrap_pulse2;
  logic [1:0] wrap_count2;
  logic       error_pulse2;
  logic [1:0] error_count2;
  logic       sticky_error2;

  int checks = 0;
  int passes = 0;

  count_monitor #(.WIDTH(4), .WRAP_W(8), .ERR_W(8), .LOCK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .count_in(count_in), .valid(valid), .clear(clear),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .error_pulse(error_pulse), .error_count(error_count), .sticky_error(sticky_error)
  );

  count_monitor #(.WIDTH(4), .WRAP_W(2), .ERR_W(2), .LOCK_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .count_in(count_in), .valid(valid), .clear(clear),
    .locked(locked2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2),
    .error_pulse(error_pulse2), .error_count(error_count2), .sticky_error(sticky_error2)
  );

  // Clock and reset defaults.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Driver: apply inputs, then wait one rising edge and settle 1 time unit after it.
  task automatic step(input logic [3:0] c, input logic v, input logic cl);
    count_in = c;
    valid    = v;
    clear    = cl;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(4'd0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", locked); else passes++;
    checks++; if (wrap_pulse !== 1'b0) $display("FAIL reset_wrap_pulse got=%b exp=0", wrap_pulse); else passes++;
    checks++; if (wrap_count !== 8'd0) $display("FAIL reset_wrap_count got=%0d exp=0", wrap_count); else passes++;
    checks++; if (error_pulse !== 1'b0) $display("FAIL reset_error_pulse got=%b exp=0", error_pulse); else passes++;
    checks++; if (error_count !== 8'd0) $display("FAIL reset_error_count got=%0d exp=0", error_count); else passes++;
    checks++; if (sticky_error !== 1'b0) $display("FAIL reset_sticky got=%b exp=0", sticky_error); else passes++;
  endtask

  // Count 0..39 from reset: lock after sampling 2, wraps at indices 16 and 32.
  task automatic test_lock_and_wrap();
    logic exp_locked;
    logic exp_wrap;
    for (int i = 0; i < 40; i++) begin
      step(4'(i), 1'b1, 1'b0);
      exp_locked = (i >= 2);
      exp_wrap   = (i == 16) || (i == 32);
      checks++; if (locked !== exp_locked) $display("FAIL lock_locked i=%0d got=%b exp=%b", i, locked, exp_locked); else passes++;
      checks++; if (wrap_pulse !== exp_wrap) $display("FAIL lock_wrap_pulse i=%0d got=%b exp=%b", i, wrap_pulse, exp_wrap); else passes++;
    end
    checks++; if (wrap_count !== 8'd2) $display("FAIL lock_wrap_count got=%0d exp=2", wrap_count); else passes++;
    checks++; if (error_count !== 8'd0) $display("FAIL lock_error_count got=%0d exp=0", error_count); else passes++;
    checks++; if (sticky_error !== 1'b0) $display("FAIL lock_sticky got=%b exp=0", sticky_error); else passes++;
  endtask

  // prev is 7 while locked. Inject 8,10,11,12, which mirrors 3,5,6,7 after prev=2.
  task automatic test_error();
    step(4'd8, 1'b1, 1'b0);
    checks++; if (error_pulse !== 1'b0) $display("FAIL err_pre_pulse got=%b exp=0", error_pulse); else passes++;
    step(4'd10, 1'b1, 1'b0);
    checks++; if (error_pulse !== 1'b1) $display("FAIL err_pulse got=%b exp=1", error_pulse); else passes++;
    checks++; if (error_count !== 8'd1) $display("FAIL err_count got=%0d exp=1", error_count); else passes++;
    checks++; if (sticky_error !== 1'b1) $display("FAIL err_sticky got=%b exp=1", sticky_error); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL err_locked_drop got=%b exp=0", locked); else passes++;
    step(4'd11, 1'b1, 1'b0);
    checks++; if (error_pulse !== 1'b0) $display("FAIL err_pulse_width got=%b exp=0", error_pulse); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL err_locked_acq got=%b exp=0", locked); else passes++;
    step(4'd12, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL err_relock got=%b exp=1", locked); else passes++;
    checks++; if (error_count !== 8'd1) $display("FAIL err_count_hold got=%0d exp=1", error_count); else passes++;
  endtask

  // From prev=12, walk to prev=9, then hold valid=0 for three cycles with junk inputs.
  task automatic test_gap();
    for (int i = 13; i < 16 + 10; i++) step(4'(i), 1'b1, 1'b0);
    step(4'hA, 1'b0, 1'b0);
    checks++; if (error_pulse !== 1'b0) $display("FAIL gap_pulse0 got=%b exp=0", error_pulse); else passes++;
    step(4'h3, 1'b0, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL gap_locked1 got=%b exp=1", locked); else passes++;
    step(4'hF, 1'b0, 1'b0);
    checks++; if (error_pulse !== 1'b0) $display("FAIL gap_pulse2 got=%b exp=0", error_pulse); else passes++;
    step(4'd10, 1'b1, 1'b0);
    checks++; if (error_pulse !== 1'b0) $display("FAIL gap_resume_pulse got=%b exp=0", error_pulse); else passes++;
    checks++; if (locked !== 1'b1) $display("FAIL gap_resume_locked got=%b exp=1", locked); else passes++;
    checks++; if (error_count !== 8'd1) $display("FAIL gap_error_count got=%0d exp=1", error_count); else passes++;
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 32; i++) step(4'(i), 1'b1, 1'b0);
    checks++; if (wrap_count !== 8'd1) $display("FAIL clr_pre_wrap got=%0d exp=1", wrap_count); else passes++;
    // A wrap on the same edge as clear still pulses, but the tally is cleared.
    step(4'd0, 1'b1, 1'b1);
    checks++; if (wrap_pulse !== 1'b1) $display("FAIL clr_wrap_pulse got=%b exp=1", wrap_pulse); else passes++;
    checks++; if (wrap_count !== 8'd0) $display("FAIL clr_wrap_count got=%0d exp=0", wrap_count); else passes++;
    checks++; if (sticky_error !== 1'b0) $display("FAIL clr_sticky got=%b exp=0", sticky_error); else passes++;
    checks++; if (locked !== 1'b1) $display("FAIL clr_locked got=%b exp=1", locked); else passes++;
    // An error on the same edge as clear pulses, but the count and sticky bit stay 0.
    step(4'd5, 1'b1, 1'b1);
    checks++; if (error_pulse !== 1'b1) $display("FAIL clr_err_pulse got=%b exp=1", error_pulse); else passes++;
    checks++; if (error_count !== 8'd0) $display("FAIL clr_err_count got=%0d exp=0", error_count); else passes++;
    checks++; if (sticky_error !== 1'b0) $display("FAIL clr_err_sticky got=%b exp=0", sticky_error); else passes++;
    step(4'd6, 1'b1, 1'b0);
    step(4'd7, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL clr_relock got=%b exp=1", locked); else passes++;
    step(4'd9, 1'b1, 1'b0);
    checks++; if (error_count !== 8'd1) $display("FAIL clr_post_err_count got=%0d exp=1", error_count); else passes++;
    checks++; if (sticky_error !== 1'b1) $display("FAIL clr_post_sticky got=%b exp=1", sticky_error); else passes++;
  endtask

  // Five errors, with a relock before each one. The 2-bit tally saturates at 3.
  task automatic test_saturate();
    logic [3:0] c;
    do_reset();
    step(4'd0, 1'b1, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    step(4'd2, 1'b1, 1'b0);
    c = 4'd2;
    for (int k = 0; k < 5; k++) begin
      c = c + 4'd2;
      step(c, 1'b1, 1'b0);
      c = c + 4'd1;
      step(c, 1'b1, 1'b0);
      c = c + 4'd1;
      step(c, 1'b1, 1'b0);
    end
    checks++; if (error_count !== 8'd5) $display("FAIL sat_err_count8 got=%0d exp=5", error_count); else passes++;
    checks++; if (error_count2 !== 2'd3) $display("FAIL sat_err_count2 got=%0d exp=3", error_count2); else passes++;
    checks++; if (locked2 !== 1'b1) $display("FAIL sat_locked2 got=%b exp=1", locked2); else passes++;
    // Wrap saturation: 0..64 produces four wraps.
    do_reset();
    for (int i = 0; i <= 64; i++) step(4'(i), 1'b1, 1'b0);
    checks++; if (wrap_count !== 8'd4) $display("FAIL sat_wrap_count8 got=%0d exp=4", wrap_count); else passes++;
    checks++; if (wrap_count2 !== 2'd3) $display("FAIL sat_wrap_count2 got=%0d exp=3", wrap_count2); else passes++;
  endtask

  // Reset while locked with nonzero tallies. valid=1 during the reset must be ignored.
  task automatic test_reset_mid();
    step(4'd2, 1'b1, 1'b0);
    step(4'd4, 1'b1, 1'b0);
    checks++; if (error_count !== 8'd1) $display("FAIL mid_pre_err got=%0d exp=1", error_count); else passes++;
    reset = 1'b1;
    step(4'd5, 1'b1, 1'b1);
    reset = 1'b0;
    checks++; if (locked !== 1'b0) $display("FAIL mid_locked got=%b exp=0", locked); else passes++;
    checks++; if (wrap_count !== 8'd0) $display("FAIL mid_wrap_count got=%0d exp=0", wrap_count); else passes++;
    checks++; if (error_count !== 8'd0) $display("FAIL mid_error_count got=%0d exp=0", error_count); else passes++;
    checks++; if (sticky_error !== 1'b0) $display("FAIL mid_sticky got=%b exp=0", sticky_error); else passes++;
    checks++; if ({wrap_pulse, error_pulse} !== 2'b00) $display("FAIL mid_pulses got=%b exp=00", {wrap_pulse, error_pulse}); else passes++;
    step(4'd7, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) $display("FAIL mid_acq0 got=%b exp=0", locked); else passes++;
    step(4'd8, 1'b1, 1'b0);
    checks++; if (locked !== 1'b0) $display("FAIL mid_acq1 got=%b exp=0", locked); else passes++;
    step(4'd9, 1'b1, 1'b0);
    checks++; if (locked !== 1'b1) $display("FAIL mid_relock got=%b exp=1", locked); else passes++;
    checks++; if (error_pulse !== 1'b0) $display("FAIL mid_no_err got=%b exp=0", error_pulse); else passes++;
  endtask

  initial begin
    reset    = 1'b1;
    count_in = 4'd0;
    valid    = 1'b0;
    clear    = 1'b0;
    test_reset();
    test_lock_and_wrap();
    test_error();
    test_gap();
    test_clear();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
Name: count_monitor

Overview:
- Downstream checker for a free-running binary up-counter: samples the counter value every clock and confirms it advances by exactly 1 per sample, modulo 2^WIDTH.
- Locks onto the sequence, reports wrap-around events and sequence errors as pulses, and accumulates saturating wrap/error tallies.
- Sits directly after the counter in simulation benches and in on-chip self-check logic.

Parameters:
- WIDTH, 4, bit width of the monitored count.
- WRAP_W, 8, width of wrap_count.
- ERR_W, 8, width of error_count.
- LOCK_CYCLES, 2, consecutive correct increments required to enter LOCKED (range 1..15).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- count_in  input  WIDTH  monitored counter value.
- valid  input  1  count_in is sampled only when high.
- clear  input  1  synchronous clear of tallies and sticky_error; FSM unaffected.
- locked  output  1  high while in LOCKED.
- wrap_pulse  output  1  one-cycle pulse per detected wrap.
- wrap_count  output  WRAP_W  saturating wrap tally.
- error_pulse  output  1  one-cycle pulse per sequence error.
- error_count  output  ERR_W  saturating error tally.
- sticky_error  output  1  set on any error; cleared only by clear or reset.

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clock.
- All outputs are registered.
  - Reset values: locked=0, wrap_pulse=0, wrap_count=0, error_pulse=0, error_count=0, sticky_error=0.
  - Internal state on reset: FSM=IDLE, prev=0, match_cnt=0.
- Sample: a rising edge with valid=1.
  - The result is visible right after that same edge, so latency is 1 clock from count_in being presented.
  - exp = prev+1 mod 2^WIDTH.
- valid=0: no comparison, and prev, FSM and tallies hold. Pulses are 0. Gaps of any length are legal.
- FSM states: IDLE, ACQUIRE, LOCKED.
  - IDLE, on a sample: prev<=count_in; match_cnt<=0; go to ACQUIRE.
  - ACQUIRE, on a sample:
    - If count_in==exp: match_cnt+1. When this reaches LOCK_CYCLES, go to LOCKED and set locked=1.
    - Otherwise: match_cnt<=0 and stay in ACQUIRE. No error is flagged in ACQUIRE.
    - prev<=count_in in both cases.
  - LOCKED, on a sample:
    - If count_in==exp: stay in LOCKED.
      - If prev==all-ones (so count_in==0): wrap_pulse=1 and wrap_count increments, saturating at 2^WRAP_W-1.
    - If count_in!=exp: error_pulse=1; error_count increments, saturating at 2^ERR_W-1; sticky_error<=1; match_cnt<=0; go to ACQUIRE; locked=0.
    - prev<=count_in in both cases.
- Wraps are counted only in LOCKED. A wrap that occurs while in ACQUIRE counts only as a match.
- Pulses last exactly one cycle and are never asserted in the cycle after a valid=0 edge.
- clear=1 on an edge:
  - wrap_count<=0, error_count<=0, sticky_error<=0.
  - clear has priority over a same-edge increment or sticky set.
  - wrap_pulse and error_pulse still fire for a same-edge event.
  - FSM, prev and locked are unaffected.
- reset has priority over everything, including clear and valid. Reset mid-operation returns to IDLE with all outputs at their reset values after the edge.
- Comparison arithmetic is unsigned, modulo 2^WIDTH. The tallies never wrap.

Test Plan:
- Reset for 1 edge, then count_in=0,1,2,… with valid=1 every cycle -> locked rises after the edge sampling 2 (LOCK_CYCLES=2) and stays 1; error_count=0.
- Continue the sequence 0..39 from reset -> wrap_pulse high for exactly one cycle after the edges sampling 0 at indices 16 and 32; final wrap_count=2; sticky_error=0.
- While locked, inject the sequence 3,5,6,7 -> error_pulse for one cycle after the edge sampling 5; error_count=1; sticky_error=1; locked=0 until after the edge sampling 7.
  - Variant with ERR_W=2: inject 5 errors -> error_count saturates at 3.
- While locked at prev=9, hold valid=0 for 3 cycles with count_in=4'hA,4'h3,4'hF, then valid=1 with count_in=10 -> no error_pulse; locked stays 1.
- Locked with wrap_count=1; present 15 then 0 with clear=1 on the edge sampling 0 -> wrap_pulse=1 on that cycle; wrap_count=0; sticky_error=0; locked stays 1.
- Reset asserted for one edge while locked with nonzero tallies -> after the edge all outputs are 0; the next sample re-enters ACQUIRE, and locked returns after 2 further correct increments.
